// File: rtl/psum_accumulator_if.sv
// Stream bundle around the partial-sum accumulator: input beats from the
// tree adder, completed group results to the consumer, plus group length.
interface psum_accumulator_if #(
   parameter int IN_WIDTH  = 32,
   parameter int ACC_WIDTH = 32,
   parameter int K_WIDTH   = 16
);
   logic        [K_WIDTH-1:0]   k;
   logic signed [IN_WIDTH-1:0]  in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic signed [ACC_WIDTH-1:0] out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_saturated;
   logic                        busy;

   modport master (
      output k, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_saturated, busy
   );

   modport slave (
      input  k, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_saturated, busy
   );
endinterface

// File: rtl/psum_accumulator.sv
// Sums K consecutive signed tree-adder results into one saturated partial
// sum, with a one-entry output buffer so the next group can accumulate
// while a finished result waits for the consumer.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no beat of the current group accepted yet (cnt == 0)
// S_ACCUM | group partially accumulated, waiting for beat cnt+1 of k_lat
module psum_accumulator #(
   parameter int IN_WIDTH  = 32,
   parameter int ACC_WIDTH = 32,
   parameter int K_WIDTH   = 16
) (
   input logic               clk,
   input logic               rst,
   psum_accumulator_if.slave bus
);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t                      state, state_nxt;
   logic        [K_WIDTH-1:0]   k_eff, k_lat, cnt, cnt_nxt;
   logic signed [ACC_WIDTH-1:0] acc, acc_nxt, in_sext, sum_clip;
   logic        [ACC_WIDTH:0]   sum_wide;
   logic                        sum_ovf;
   logic                        sat, sat_nxt;
   logic                        last_beat, accept, xfer;
   logic                        in_ready_c, busy_c;
   logic signed [ACC_WIDTH-1:0] out_data_q;
   logic                        out_valid_q, out_sat_q;

   assign k_eff   = (bus.k == '0) ? K_WIDTH'(1) : bus.k;
   assign in_sext = ACC_WIDTH'(bus.in_data);
   assign cnt_nxt = cnt + K_WIDTH'(1);

   // Full-precision add one bit wider than the accumulator, then clip.
   assign sum_wide = {acc[ACC_WIDTH-1], acc} + {in_sext[ACC_WIDTH-1], in_sext};
   assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
   assign sum_clip = sum_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                             : sum_wide[ACC_WIDTH-1:0];

   assign accept = bus.in_valid && in_ready_c;
   assign xfer   = out_valid_q && bus.out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state: leave IDLE on a non-final first beat, return on the final beat.
   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (last_beat) state_nxt = S_IDLE;
         else           state_nxt = S_ACCUM;
      end
   end

   // Outputs: only the completing beat can stall, and only when the buffer
   // is full and the consumer is not draining it this cycle.
   always_comb begin
      last_beat  = 1'b0;
      busy_c     = 1'b0;
      case (state)
         S_IDLE:  last_beat = (k_eff == K_WIDTH'(1));
         S_ACCUM: begin
            last_beat = (cnt_nxt == k_lat);
            busy_c    = 1'b1;
         end
         default: last_beat = 1'b0;
      endcase
      in_ready_c = !(last_beat && out_valid_q && !bus.out_ready);
   end

   // Candidate accumulator value for the beat presented this cycle.
   always_comb begin
      acc_nxt = sum_clip;
      sat_nxt = sat | sum_ovf;
      if (state == S_IDLE) begin
         acc_nxt = in_sext;
         sat_nxt = 1'b0;
      end
   end

   // Accumulator, beat counter and output buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         sat         <= 1'b0;
         k_lat       <= K_WIDTH'(1);
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            if (state == S_IDLE) k_lat <= k_eff;
            if (last_beat) begin
               out_data_q <= acc_nxt;
               out_sat_q  <= sat_nxt;
               acc        <= '0;
               cnt        <= '0;
               sat        <= 1'b0;
            end else begin
               acc <= acc_nxt;
               cnt <= cnt_nxt;
               sat <= sat_nxt;
            end
         end
         if (accept && last_beat) out_valid_q <= 1'b1;
         else if (xfer)           out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.busy          = busy_c;
   assign bus.out_data      = out_data_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_saturated = out_sat_q;

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Output-side accumulation stage placed directly downstream of `config_binary_tree_adder`. It takes the adder's signed per-cycle reduction result and sums K consecutive results into one output partial sum, with saturation. This lets a dot product longer than the tree width be reduced over several cycles. The output is held in a one-entry buffer so the next group can accumulate while a finished result waits for the consumer.

## Interface
Parameters:
- `IN_WIDTH`, 32, width of the signed input sum; matches the tree adder `out`.
- `ACC_WIDTH`, 32, width of the signed accumulator and result; must be ≥ `IN_WIDTH`.
- `K_WIDTH`, 16, width of the group-length field.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `k`  in  `K_WIDTH`  — number of input beats per result. Sampled only on the first accepted beat of a group. `k=0` is treated as 1.
- `in_data`  in  `IN_WIDTH` signed  — tree adder sum.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — block accepts a beat this cycle.
- `out_data`  out  `ACC_WIDTH` signed  — accumulated group result.
- `out_valid`  out  1  — `out_data` holds a completed result.
- `out_ready`  in  1  — consumer takes the result.
- `out_saturated`  out  1  — the group clipped at least once; qualified by `out_valid`.
- `busy`  out  1  — a group is partially accumulated (beat count > 0).

## Operation
- Beat acceptance: a beat is accepted when `in_valid && in_ready`. Result transfer occurs when `out_valid && out_ready`.
- Accumulator side has two states:
  - IDLE: no beats of the current group yet. On accept: `acc = sext(in_data)`, `cnt = 1`, latch `k_lat = max(k,1)`, `sat = 0`. Go to ACCUM, unless `k_lat == 1`, in which case the group completes in the same cycle.
  - ACCUM: on accept, `acc = sat_add(acc, sext(in_data))`, `cnt++`. When `cnt` reaches `k_lat` the group completes.
- `sat_add`: full-precision sum, clipped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Set sticky `sat` whenever clipping occurs.
- Group completion: result = updated acc, flag = updated sat.
  - Result and flag are written into the output buffer.
  - Accumulator returns to IDLE. Acc is cleared to 0 and `k` is resampled at the next group's first beat.
- Output buffer (one entry): `out_valid` is set on completion and cleared on transfer.
  - Completion and transfer in the same cycle: buffer is overwritten and `out_valid` stays 1.
- `in_ready = !(completing_beat_pending && out_valid && !out_ready)`.
  - Only the last beat of a group can stall, and only when the buffer is full and not draining.
  - Every other beat is accepted regardless of output backpressure.
  - `in_ready` depends combinationally on `out_ready`, `out_valid`, `cnt` and `k_lat`/`k`. It never depends on `in_valid`.
- `busy = (state == ACCUM)`.
- Changes to `k` during a group are ignored.

## Timing
- Reset (synchronous, `rst=1` at a clock edge):
  - `out_valid=0`, `out_data=0`, `out_saturated=0`, `busy=0`.
  - State IDLE, acc=0, cnt=0.
  - Any partial group and any buffered result are discarded.
  - `in_ready` is 1 in the cycle after reset.
- Latency: a result is visible (`out_valid=1`) in the cycle after its last beat is accepted.
- Throughput: one beat per cycle sustained whenever `out_ready=1`. With `k=1`, one result per cycle.
- `out_data` and `out_saturated` are stable while `out_valid && !out_ready`.
- Simultaneous last-beat accept and output transfer in the same cycle: new result is loaded, no bubble.
- Beats with `in_valid=0` leave all state unchanged.

## Test plan
- Basic: `k=4`, beats 36, −4, 0, 183 back-to-back with `out_ready=1` → one cycle after the 4th beat, `out_valid=1`, `out_data=215`, `out_saturated=0`, `busy` 1 during beats 2–4.
- Saturation: `k=2`, beats 0x7FFFFFFF then 5 → `out_data=0x7FFFFFFF`, `out_saturated=1`. Next group `k=2`, beats 0x80000000 then −1 → `out_data=0x80000000`, `out_saturated=1`. Group `k=2`, beats 3 and −3 → 0, `out_saturated=0`.
- Backpressure: `out_ready=0`, `k=1`, beats 7 then 9.
  - 7 is buffered.
  - `in_ready=0` while 9 is presented, and 9 is not consumed.
  - Raise `out_ready` → 7 transfers and 9 is accepted in the same cycle. Next cycle `out_data=9`.
  - No value is lost or duplicated.
- Non-completing beats under backpressure: `out_ready=0` with a result buffered, `k=3`, beats 1, 2 → both accepted (`in_ready=1`). Beat 3 stalls until `out_ready=1`, then `out_data=6`.
- Edge k: `k=0`, beat −12 → treated as `k=1`, result −12. Change `k` from 3 to 1 after the first beat of a group → group still needs 3 beats.
- Reset mid-operation: `k=4`, accept 2 beats (10, 20), assert `rst` one cycle → `busy=0`, `out_valid=0`. Then `k=2`, beats 1, 1 → `out_data=2` (partial sum 30 discarded). 200 random groups (random `k` 1–16, random 16-bit×2-lane sums, random `out_ready`) checked against a saturating reference model.
